serial_magnitude_comparator: RTL and testbench
==============================================

// Module: serial_magnitude_comparator
//
// PURPOSE
//   Multi-bit magnitude comparator built around the team's 1-bit compare stage.
//   Loads two WIDTH-bit operands on a start request and walks them MSB-first,
//   one bit per clock, through an internal 1-bit greater/less/equal stage.
//   Resolves the first differing bit into a registered greater/less/equal
//   result and reports completion with a one-cycle done pulse.
//   Serves area-constrained paths where a parallel WIDTH-bit comparator is not justified.
//
// PARAMETERS
//   WIDTH       8   operand width in bits; legal range >= 2
//   EARLY_EXIT  1   1: finish on first differing bit; 0: always examine all WIDTH bits
//
// PORTS
//   clk          input   1      rising-edge clock
//   rst_n        input   1      asynchronous active-low reset
//   start        input   1      request; sampled only when ready=1
//   A            input   WIDTH  operand A, captured on accepted start
//   B            input   WIDTH  operand B, captured on accepted start
//   ready        output  1      1 in IDLE (a start will be accepted)
//   busy         output  1      1 in COMPARE or DONE (always ~ready)
//   done         output  1      one-cycle pulse: result outputs just updated
//   A_greater_B  output  1      registered result, A > B (unsigned)
//   A_less_B     output  1      registered result, A < B (unsigned)
//   A_equal_B    output  1      registered result, A == B
//
// BEHAVIOUR
//   - Reset (async assert, sync release):
//     - state=IDLE, ready=1, busy=0, done=0.
//     - All three result outputs 0; shift registers, bit counter and decided flag cleared.
//   - FSM states: IDLE -> COMPARE -> DONE -> IDLE.
//   - IDLE, start=1 at edge E0:
//     - Capture A and B into shift regs sa/sb.
//     - Set counter to WIDTH-1, clear decided flag, go to COMPARE.
//     - start=0: remain in IDLE.
//   - COMPARE: each cycle, the 1-bit stage compares sa[WIDTH-1] with sb[WIDTH-1].
//     At the edge:
//     - If not decided and the bits differ: record gt/lt and set decided.
//     - Shift sa/sb left by 1 (zero fill) and decrement the counter.
//     - EARLY_EXIT=1 and bits differ: go to DONE.
//     - Counter == 0: go to DONE. If nothing was decided, the result is equal.
//     - On every edge into DONE: write A_greater_B, A_less_B, A_equal_B,
//       exactly one of them 1.
//   - DONE: done=1 for this single cycle; next edge goes to IDLE unconditionally.
//   - Latency, start sampled at E0 and first differing bit at index k:
//     - EARLY_EXIT=1: result written at edge E(WIDTH-k); done high in the following cycle.
//     - EARLY_EXIT=0 or equal operands: result written at edge E(WIDTH);
//       done high in the following cycle.
//   - Result outputs hold their last values until the next edge into DONE.
//     They do not clear on start.
//   - start while busy=1 (COMPARE or DONE) is ignored. It is not queued.
//     A and B are don't-care while busy.
//   - Minimum start-to-start spacing: (bits examined) + 2 cycles.
//     start held high re-triggers on the first IDLE cycle.
//   - With EARLY_EXIT=0, a later differing bit never overrides the first
//     recorded one (MSB dominates).
//   - rst_n asserted mid-operation aborts immediately to the reset state.
//     No done pulse; results return to 0.
//
// TESTING (WIDTH=8 unless stated)
//   1. A=8'hA5, B=8'hA5, start at E0
//      -> done high E8..E9; A_equal_B=1, others 0; ready=1 after E9.
//   2. EARLY_EXIT=1, A=8'h80, B=8'h7F
//      -> done high E1..E2; A_greater_B=1.
//      Then A=8'h12, B=8'h13 -> done 8 cycles after start edge; A_less_B=1.
//   3. EARLY_EXIT=0, A=8'h80, B=8'h7F
//      -> done still E8..E9, A_greater_B=1 (later bits differ the other way, MSB wins).
//   4. Start A=8'h00, B=8'hFF; pulse start with A=B=8'h55 at E3 (busy)
//      -> second request ignored; single done with A_less_B=1; results held afterwards.
//   5. Start A=8'h01, B=8'h00 (EARLY_EXIT=1); assert rst_n=0 at E4
//      -> outputs 0 and ready=1 immediately, no done pulse.
//      After release, A=8'hFF, B=8'hFE completes normally with greater.
//   6. start tied high, alternating operand pairs
//      -> each accepted on IDLE cycles only; done pulses exactly one cycle;
//      one-hot result checked against a reference model for 1000 random pairs, both EARLY_EXIT values.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// serial_magnitude_comparator
//
// Bit-serial unsigned magnitude comparator. On an accepted start it captures
// two WIDTH-bit operands and walks them MSB-first, one bit per clock, through
// a 1-bit greater/less/equal stage. The first differing bit decides the
// result. The result is registered, and completion is flagged by a one-cycle
// done pulse.
//
// Parameters
//   WIDTH       operand width in bits (>= 2)
//   EARLY_EXIT  1: finish on the first differing bit
//               0: always examine all WIDTH bits
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        compare request, sampled only while ready=1
//   A, B         operands, captured on an accepted start
//   ready        idle, a start will be accepted
//   busy         compare in progress or result being reported (~ready)
//   done         one-cycle pulse, result outputs were just updated
//   A_greater_B  registered result, A > B
//   A_less_B     registered result, A < B
//   A_equal_B    registered result, A == B
// -----------------------------------------------------------------------------
module serial_magnitude_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             A_greater_B,
    output logic             A_less_B,
    output logic             A_equal_B
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             gt_rec_q, gt_rec_d;
    logic             lt_rec_q, lt_rec_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    // 1-bit compare stage on the current MSBs, merged with any earlier
    // decision so that the first differing bit always dominates.
    logic bit_a, bit_b, bit_diff;
    logic stage_gt, stage_lt, stage_decided;

    always_comb begin
        bit_a         = sa_q[WIDTH-1];
        bit_b         = sb_q[WIDTH-1];
        bit_diff      = bit_a ^ bit_b;
        stage_gt      = decided_q ? gt_rec_q : (bit_diff & bit_a);
        stage_lt      = decided_q ? lt_rec_q : (bit_diff & bit_b);
        stage_decided = decided_q | bit_diff;
    end

    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        gt_rec_d  = gt_rec_q;
        lt_rec_d  = lt_rec_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        eq_d      = eq_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d      = A;
                    sb_d      = B;
                    cnt_d     = CW'(WIDTH - 1);
                    decided_d = 1'b0;
                    gt_rec_d  = 1'b0;
                    lt_rec_d  = 1'b0;
                    state_d   = S_COMPARE;
                end
            end

            S_COMPARE: begin
                sa_d      = {sa_q[WIDTH-2:0], 1'b0};
                sb_d      = {sb_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CW'(1);
                decided_d = stage_decided;
                gt_rec_d  = stage_gt;
                lt_rec_d  = stage_lt;
                if ((EARLY_EXIT && bit_diff) || (cnt_q == '0)) begin
                    // Nothing decided after the last bit means equal.
                    state_d = S_DONE;
                    gt_d    = stage_gt;
                    lt_d    = stage_lt;
                    eq_d    = ~stage_decided;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_rec_q  <= 1'b0;
            lt_rec_q  <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            gt_rec_q  <= gt_rec_d;
            lt_rec_q  <= lt_rec_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            eq_q      <= eq_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign busy        = ~ready;
    assign done        = (state_q == S_DONE);
    assign A_greater_B = gt_q;
    assign A_less_B    = lt_q;
    assign A_equal_B   = eq_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_magnitude_comparator
//
// Drives two comparator instances sharing clock, reset and operands:
// index 0 has EARLY_EXIT=0 (full scan), index 1 has EARLY_EXIT=1. Each
// instance has its own start. Expected latency and result come from a
// reference model that works on whole operands with ordinary arithmetic.
// -----------------------------------------------------------------------------
module tb_serial_magnitude_comparator;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   st;
    logic [W-1:0] A, B;
    logic [1:0]   rdy, bsy, dn, gt, lt, eq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_full (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .A(A), .B(B),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]),
        .A_greater_B(gt[0]), .A_less_B(lt[0]), .A_equal_B(eq[0])
    );

    serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_early (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .A(A), .B(B),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]),
        .A_greater_B(gt[1]), .A_less_B(lt[1]), .A_equal_B(eq[1])
    );

    // Reference model: cycles from accepting edge to the edge writing the result.
    function automatic int lat_of(input int ee, input logic [W-1:0] a, input logic [W-1:0] b);
        int x;
        int k;
        if (a == b || ee == 0) return W;
        x = int'(a ^ b);
        k = 0;
        while (x > 1) begin
            x = x >> 1;
            k++;
        end
        return W - k;
    endfunction

    function automatic logic [2:0] res_of(input logic [W-1:0] a, input logic [W-1:0] b);
        return {a > b, a < b, a == b};
    endfunction

    function automatic logic [2:0] res_obs(input int s);
        return {gt[s], lt[s], eq[s]};
    endfunction

    function automatic logic [W-1:0] rand_b(input logic [W-1:0] a);
        int mode;
        mode = int'($urandom_range(0, 3));
        if (mode == 0) return a;
        if (mode == 1) return a ^ (W'(1) << $urandom_range(0, W - 1));
        return W'($urandom);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        st    = 2'b00;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({rdy[s], bsy[s], dn[s]} !== 3'b100) begin
                failures++;
                $display("FAIL reset_status[%0d]: got rdy/bsy/done=%b expected 100", s, {rdy[s], bsy[s], dn[s]});
            end
            checks++;
            if (res_obs(s) !== 3'b000) begin
                failures++;
                $display("FAIL reset_result[%0d]: got %b expected 000", s, res_obs(s));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One operation on instance s; optionally pulses start with A=B=55 so
    // that it is high across edge E(inj) while the instance is busy.
    task automatic run_op(input int s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj, input string nm);
        int         lat;
        logic [2:0] er;
        int         first;
        int         ndone;
        lat   = lat_of(s, a, b);
        er    = res_of(a, b);
        first = -1;
        ndone = 0;
        @(posedge clk);
        #1;
        A     = a;
        B     = b;
        st[s] = 1'b1;
        @(posedge clk);            // E0
        #1;
        st[s] = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        for (int c = 1; c <= W + 3; c++) begin
            if (c == inj) begin
                st[s] = 1'b1;
                A     = 8'h55;
                B     = 8'h55;
            end
            if (c == inj + 1) st[s] = 1'b0;
            @(posedge clk);        // E(c)
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if ({rdy[s], bsy[s]} !== 2'b01) begin
                    failures++;
                    $display("FAIL %s busy_after_start: got rdy/bsy=%b expected 01", nm, {rdy[s], bsy[s]});
                end
            end
            if (dn[s] === 1'b1) begin
                ndone++;
                if (first < 0) begin
                    first = c;
                    checks++;
                    if (res_obs(s) !== er) begin
                        failures++;
                        $display("FAIL %s result_at_done: got %b expected %b", nm, res_obs(s), er);
                    end
                end
            end
        end
        checks++;
        if (first != lat) begin
            failures++;
            $display("FAIL %s done_latency: got %0d expected %0d", nm, first, lat);
        end
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL %s done_pulses: got %0d expected 1", nm, ndone);
        end
        checks++;
        if ({rdy[s], res_obs(s)} !== {1'b1, er}) begin
            failures++;
            $display("FAIL %s final_state: got rdy,res=%b expected %b", nm, {rdy[s], res_obs(s)}, {1'b1, er});
        end
    endtask

    task automatic test_equal();
        run_op(0, 8'hA5, 8'hA5, 0, "equal_full");
        run_op(1, 8'hA5, 8'hA5, 0, "equal_early");
    endtask

    task automatic test_early_exit();
        run_op(1, 8'h80, 8'h7F, 0, "early_msb");
        run_op(1, 8'h12, 8'h13, 0, "early_lsb");
    endtask

    task automatic test_full_scan();
        run_op(0, 8'h80, 8'h7F, 0, "full_msb_wins");
        run_op(0, 8'h12, 8'h13, 0, "full_lsb");
    endtask

    task automatic test_busy_ignore();
        run_op(0, 8'h00, 8'hFF, 3, "busy_ignore");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({rdy[0], dn[0], res_obs(0)} !== 5'b10010) begin
                failures++;
                $display("FAIL busy_hold: got rdy,done,res=%b expected 10010", {rdy[0], dn[0], res_obs(0)});
            end
        end
    endtask

    task automatic test_reset_abort();
        int ndone;
        ndone = 0;
        @(posedge clk);
        #1;
        A     = 8'h01;
        B     = 8'h00;
        st[1] = 1'b1;
        @(posedge clk);            // E0
        #1;
        st[1] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (dn[1] === 1'b1) ndone++;
        end
        @(posedge clk);            // E4
        #1;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({rdy[s], bsy[s], dn[s], res_obs(s)} !== 6'b100000) begin
                failures++;
                $display("FAIL abort_state[%0d]: got rdy,bsy,done,res=%b expected 100000", s,
                         {rdy[s], bsy[s], dn[s], res_obs(s)});
            end
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", ndone);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1, 8'hFF, 8'hFE, 0, "abort_recover");
    endtask

    // start held high on both instances; the model tracks each one's
    // remaining busy edges and the result it should show.
    task automatic test_back_to_back();
        localparam int N     = 1000;
        localparam int LIMIT = 40000;
        int         rem [2];
        int         acc [2];
        logic [2:0] pend[2];
        logic [2:0] cur [2];
        logic [5:0] exp_v;
        logic [5:0] got_v;
        int         cyc;
        @(negedge clk);
        rst_n = 1'b0;
        st    = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            rem[s]  = 0;
            acc[s]  = 0;
            pend[s] = 3'b000;
            cur[s]  = 3'b000;
        end
        A   = W'($urandom);
        B   = rand_b(A);
        st  = 2'b11;
        cyc = 0;
        while ((acc[0] < N || acc[1] < N) && cyc < LIMIT) begin
            @(posedge clk);
            for (int s = 0; s < 2; s++) begin
                if (rem[s] == 0) begin
                    pend[s] = res_of(A, B);
                    rem[s]  = lat_of(s, A, B) + 1;
                    acc[s]++;
                end else begin
                    rem[s]--;
                    if (rem[s] == 1) cur[s] = pend[s];
                end
            end
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                exp_v = {rem[s] == 0, rem[s] != 0, rem[s] == 1, cur[s]};
                got_v = {rdy[s], bsy[s], dn[s], res_obs(s)};
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL b2b[%0d] cycle %0d: got rdy,bsy,done,res=%b expected %b", s, cyc, got_v, exp_v);
                end
            end
            A = W'($urandom);
            B = rand_b(A);
            cyc++;
        end
        st = 2'b00;
        checks++;
        if (cyc >= LIMIT) begin
            failures++;
            $display("FAIL b2b_timeout: got %0d cycles expected fewer than %0d", cyc, LIMIT);
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_early_exit();
        test_full_scan();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
